// File: rtl/mb_fetch_addr.sv
// Turns a 4x4 block coordinate {row, col} into frame-buffer read addresses.
// Define MB_FETCH_NEIGHBOR_EN to also emit the intra-prediction neighbour samples.
module mb_fetch_addr #(
  parameter int WIDTH  = 720,
  parameter int LENGTH = 1280,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mb_valid,
  output logic              mb_ready,
  input  logic [31:0]       mbnumber,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_kind,
  output logic              rd_last,
  output logic              err_oob
);

  typedef enum logic [1:0] {IDLE, CALC, NBR, PIX} state_t;

  localparam logic [15:0]       WIDTH_16  = 16'(WIDTH);
  localparam logic [15:0]       LENGTH_16 = 16'(LENGTH);
  localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(WIDTH - 3);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [15:0]       row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic              oob, fire;
  logic [ADDR_W-1:0] calcBase;

`ifdef MB_FETCH_NEIGHBOR_EN
  logic [1:0] kind_q, kind_d;
  logic       hasTop, hasLeft;
  assign hasTop  = (row_q != 16'd0);
  assign hasLeft = (col_q != 16'd0);
  assign rd_kind = kind_q;
`else
  assign rd_kind = 2'b00;
`endif

  // The only multiplier; everything after CALC steps with running adders.
  assign calcBase = ADDR_W'(row_q) * WIDTH_A + ADDR_W'(col_q);
  assign oob = (mbnumber[31:16] >= LENGTH_16) || (mbnumber[15:0] >= WIDTH_16) ||
               (mbnumber[17:16] != 2'b00) || (mbnumber[1:0] != 2'b00);
  assign fire = valid_q && rd_ready;

  assign mb_ready = (state_q == IDLE);
  assign rd_valid = valid_q;
  assign rd_addr  = addr_q;
  assign rd_last  = last_q;
  assign err_oob  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MB_FETCH_NEIGHBOR_EN
      kind_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef MB_FETCH_NEIGHBOR_EN
      kind_q  <= kind_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    base_d  = base_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;
`ifdef MB_FETCH_NEIGHBOR_EN
    kind_d  = kind_q;
`endif
    case (state_q)
      IDLE: begin
        if (mb_valid) begin
          row_d = mbnumber[31:16];
          col_d = mbnumber[15:0];
          if (oob) err_d = 1'b1;
          else     state_d = CALC;
        end
      end
      CALC: begin
        base_d = calcBase;
`ifdef MB_FETCH_NEIGHBOR_EN
        state_d = (hasTop || hasLeft) ? NBR : PIX;
`else
        state_d = PIX;
`endif
      end
`ifdef MB_FETCH_NEIGHBOR_EN
      // kind_q doubles as the neighbour-group tracker: 3 top-left, 1 top, 2 left.
      NBR: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          cnt_d   = 4'd0;
          if (hasTop && hasLeft) begin
            addr_d = base_q - WIDTH_A - ONE_A;
            kind_d = 2'd3;
          end else if (hasTop) begin
            addr_d = base_q - WIDTH_A;
            kind_d = 2'd1;
          end else begin
            addr_d = base_q - ONE_A;
            kind_d = 2'd2;
          end
        end else if (fire) begin
          if (kind_q == 2'd3) begin
            addr_d = addr_q + ONE_A;
            kind_d = 2'd1;
            cnt_d  = 4'd0;
          end else if (cnt_q[1:0] != 2'd3) begin
            addr_d = (kind_q == 2'd1) ? addr_q + ONE_A : addr_q + WIDTH_A;
            cnt_d  = cnt_q + 4'd1;
          end else if (kind_q == 2'd1 && hasLeft) begin
            addr_d = base_q - ONE_A;
            kind_d = 2'd2;
            cnt_d  = 4'd0;
          end else begin
            addr_d  = base_q;
            kind_d  = 2'd0;
            cnt_d   = 4'd0;
            state_d = PIX;
          end
        end
      end
`endif
      PIX: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = base_q;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
`ifdef MB_FETCH_NEIGHBOR_EN
          kind_d  = 2'd0;
`endif
        end else if (fire) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            addr_d = (cnt_q[1:0] == 2'd3) ? addr_q + STEP_ROW : addr_q + ONE_A;
            last_d = (cnt_q == 4'd14);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
